// File: rtl/uart_hex_printer_pkg.sv
// Shared ASCII constants, FSM state type and helpers for the UART hex printer.
package uart_hex_printer_pkg;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_X  = 8'h78;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitRdy,
    StReq,
    StRel
  } state_e;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return CH_0 + {4'h0, nib};
    end
    return CH_A + {4'h0, nib} - 8'd10;
  endfunction

  function automatic int unsigned num_chars(input int unsigned data_w,
                                            input int unsigned prefix_en,
                                            input int unsigned newline_en);
    return ((prefix_en != 0) ? 2 : 0) + data_w / 4 + ((newline_en != 0) ? 2 : 0);
  endfunction

endpackage

// File: rtl/uart_hex_printer.sv
// Prints each accepted word as ASCII hex ("0x..."+CRLF) over a byte-wide tx_en/tx_ready
// handshake, one character per full request/release cycle.
module uart_hex_printer
  import uart_hex_printer_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PREFIX_EN  = 1,
  parameter int unsigned NEWLINE_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [7:0]        tx_byte_o,
  output logic              tx_en_o,
  input  logic              tx_ready_i,
  output logic              busy_o
);

  localparam int unsigned NPre  = (PREFIX_EN != 0) ? 2 : 0;
  localparam int unsigned NDig  = DATA_W / 4;
  localparam int unsigned NChar = num_chars(DATA_W, PREFIX_EN, NEWLINE_EN);
  localparam int unsigned IdxW  = $clog2(NChar + 1);

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NChar - 1);
  localparam logic [IdxW-1:0] IdxCr   = IdxW'(NPre + NDig);
  localparam logic [IdxW-1:0] IdxLf   = IdxW'(NPre + NDig + 1);

  state_e              state_q;
  logic [DATA_W-1:0]   word_q;
  logic [IdxW-1:0]     idx_q;
  logic [7:0]          tx_byte_q;
  logic                tx_en_q;
  logic                busy_q;

  logic                is_prefix;
  logic                is_cr;
  logic                is_lf;
  logic                is_digit;
  logic [7:0]          cur_char;

  if (PREFIX_EN != 0) begin : g_prefix
    assign is_prefix = (idx_q < IdxW'(2));
  end else begin : g_no_prefix
    assign is_prefix = 1'b0;
  end

  if (NEWLINE_EN != 0) begin : g_newline
    assign is_cr = (idx_q == IdxCr);
    assign is_lf = (idx_q == IdxLf);
  end else begin : g_no_newline
    assign is_cr = 1'b0;
    assign is_lf = 1'b0;
  end

  assign is_digit = ~(is_prefix | is_cr | is_lf);

  // Digits come from the top nibble of the shift register, consumed MSB first.
  always_comb begin
    cur_char = hex_ascii(word_q[DATA_W-1 -: 4]);
    if (is_prefix) begin
      cur_char = idx_q[0] ? CH_X : CH_0;
    end else if (is_cr) begin
      cur_char = CH_CR;
    end else if (is_lf) begin
      cur_char = CH_LF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      word_q    <= '0;
      idx_q     <= '0;
      tx_byte_q <= 8'h00;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            word_q  <= in_data_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          tx_byte_q <= cur_char;
          if (is_digit) begin
            word_q <= word_q << 4;
          end
          state_q <= StWaitRdy;
        end
        StWaitRdy: begin
          if (tx_ready_i) begin
            tx_en_q <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          // Only the falling edge of tx_ready matters here; a high glitch is ignored.
          if (!tx_ready_i) begin
            tx_en_q <= 1'b0;
            state_q <= StRel;
          end
        end
        StRel: begin
          if (tx_ready_i) begin
            if (idx_q == IdxLast) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              state_q <= StLoad;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o = (state_q == StIdle);
  assign tx_byte_o  = tx_byte_q;
  assign tx_en_o    = tx_en_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_hex_printer.sv
// Bench for uart_hex_printer: a 32-bit "0x..CRLF" instance and an 8-bit bare-digit instance,
// each driven by a small UART ready/busy model with fixed or random delays.
module tb_uart_hex_printer;

  logic        clk;
  logic        rst;
  logic [31:0] in_data0;
  logic [7:0]  in_data1;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  tx_byte  [2];
  logic        tx_en    [2];
  logic        tx_ready [2];
  logic        busy     [2];

  int errors;
  int checks;
  bit rand_mode;

  logic [7:0] got0[$];
  logic [7:0] got1[$];

  uart_hex_printer #(.DATA_W(32), .PREFIX_EN(1), .NEWLINE_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (in_data0),
    .in_valid_i (in_valid[0]),
    .in_ready_o (in_ready[0]),
    .tx_byte_o  (tx_byte[0]),
    .tx_en_o    (tx_en[0]),
    .tx_ready_i (tx_ready[0]),
    .busy_o     (busy[0])
  );

  uart_hex_printer #(.DATA_W(8), .PREFIX_EN(0), .NEWLINE_EN(0)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (in_data1),
    .in_valid_i (in_valid[1]),
    .in_ready_o (in_ready[1]),
    .tx_byte_o  (tx_byte[1]),
    .tx_en_o    (tx_en[1]),
    .tx_ready_i (tx_ready[1]),
    .busy_o     (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fall_dly();
    return rand_mode ? int'($urandom_range(20, 1)) : 2;
  endfunction

  function automatic int rise_dly();
    return rand_mode ? int'($urandom_range(20, 1)) : 3;
  endfunction

  // UART model: takes the byte on tx_en, drops tx_ready after a delay, raises it again
  // a delay after tx_en falls. Also watches the handshake rules on every cycle.
  int         mst  [2];
  int         cnt  [2];
  logic [7:0] held [2];
  logic       prev_en [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      tx_ready[k] = 1'b1;
      mst[k]      = 0;
      prev_en[k]  = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          mst[k]      = 0;
          tx_ready[k] = 1'b1;
          prev_en[k]  = 1'b0;
        end else begin
          if (tx_en[k] && !prev_en[k]) check("tx_en_rise_while_not_ready", tx_ready[k], 1);
          if (mst[k] != 0) check("tx_byte_stable", tx_byte[k], held[k]);
          case (mst[k])
            0: if (tx_en[k]) begin
              held[k] = tx_byte[k];
              if (k == 0) got0.push_back(tx_byte[k]);
              else        got1.push_back(tx_byte[k]);
              cnt[k] = fall_dly();
              mst[k] = 1;
            end
            1: begin
              cnt[k]--;
              if (cnt[k] <= 0) begin
                tx_ready[k] = 1'b0;
                mst[k]      = 2;
              end
            end
            2: if (!tx_en[k]) begin
              cnt[k] = rise_dly();
              mst[k] = 3;
            end
            default: begin
              cnt[k]--;
              if (cnt[k] <= 0) begin
                tx_ready[k] = 1'b1;
                mst[k]      = 0;
              end
            end
          endcase
          prev_en[k] = tx_en[k];
        end
      end
    end
  end

  // Presents a word and returns after the edge that accepts it (at +1 after that edge).
  task automatic accept(input int k, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    if (k == 0) in_data0 = d;
    else        in_data1 = d[7:0];
    in_valid[k] = 1'b1;
    for (int n = 0; n < 3000 && !ok; n++) begin
      if (in_ready[k]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int k);
    for (int n = 0; n < 3000 && busy[k]; n++) begin
      @(posedge clk);
      #1;
    end
    check("busy_clears", busy[k], 0);
  endtask

  task automatic check_text(input int k, input logic [191:0] exp, input int n);
    logic [7:0] b;
    int sz;
    sz = (k == 0) ? got0.size() : got1.size();
    check("byte_count", sz, n);
    for (int i = 0; i < n && i < sz; i++) begin
      b = (k == 0) ? got0[i] : got1[i];
      check("text_byte", b, exp[8*n-1-8*i -: 8]);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [95:0] exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'hDEADBEEF, 96'h30_78_44_45_41_44_42_45_45_46_0D_0A};
    tbl[1] = '{32'h0000000A, 96'h30_78_30_30_30_30_30_30_30_41_0D_0A};
    tbl[2] = '{32'h12345678, 96'h30_78_31_32_33_34_35_36_37_38_0D_0A};
    tbl[3] = '{32'h9ABCDEF0, 96'h30_78_39_41_42_43_44_45_46_30_0D_0A};
    tbl[4] = '{32'h00000001, 96'h30_78_30_30_30_30_30_30_30_31_0D_0A};

    errors      = 0;
    checks      = 0;
    rand_mode   = 1'b0;
    rst         = 1'b1;
    in_data0    = '0;
    in_data1    = '0;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;

    #12;
    for (int k = 0; k < 2; k++) begin
      check("reset_tx_en", tx_en[k], 0);
      check("reset_tx_byte", tx_byte[k], 8'h00);
      check("reset_busy", busy[k], 0);
      check("reset_in_ready", in_ready[k], 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table: every vector with fixed delays, then again with random delays.
    for (int rm = 0; rm < 2; rm++) begin
      rand_mode = (rm != 0);
      for (int v = 0; v < 5; v++) begin
        got0.delete();
        accept(0, tbl[v].data);
        in_valid[0] = 1'b0;
        in_data0    = 32'hFFFF_FFFF;
        check("busy_after_accept", busy[0], 1);
        check("in_ready_low_busy", in_ready[0], 0);
        wait_idle(0);
        check_text(0, {96'h0, tbl[v].exp}, 12);
      end
    end
    rand_mode = 1'b0;

    // Back-to-back: valid held high across two words.
    got0.delete();
    accept(0, tbl[2].data);
    accept(0, tbl[3].data);
    check("second_accept_after_first_done", got0.size(), 12);
    in_valid[0] = 1'b0;
    wait_idle(0);
    check_text(0, {tbl[2].exp, tbl[3].exp}, 24);

    // Reset during the third character.
    got0.delete();
    accept(0, tbl[0].data);
    in_valid[0] = 1'b0;
    for (int n = 0; n < 500 && got0.size() < 3; n++) begin
      @(posedge clk);
      #1;
    end
    check("reached_third_char", got0.size(), 3);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_tx_en", tx_en[0], 0);
    check("midreset_busy", busy[0], 0);
    check("midreset_in_ready", in_ready[0], 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    got0.delete();
    accept(0, tbl[4].data);
    in_valid[0] = 1'b0;
    wait_idle(0);
    check_text(0, {96'h0, tbl[4].exp}, 12);

    // 8-bit instance, no prefix and no newline.
    got1.delete();
    accept(1, 32'h5A);
    in_valid[1] = 1'b0;
    wait_idle(1);
    check_text(1, 192'h35_41, 2);
    got1.delete();
    rand_mode = 1'b1;
    accept(1, 32'hF0);
    in_valid[1] = 1'b0;
    wait_idle(1);
    check_text(1, 192'h46_30, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
